// File: rtl/add_pkg.sv
// add_pkg: shared helpers for the pipelined adder/subtractor (add_pipe).
// Holds the chunk-width helper, the signed-overflow rule and the saturation
// constants used when ADD_PIPE_SAT_EN is defined.
package add_pkg;

    // Widest result the saturation constants can describe.
    localparam int SAT_MAX_W = 64;

    // Width of one pipeline slice; DW is expected to be a multiple of STAGES.
    function automatic int chunk_width(input int dw, input int stages);
        return dw / stages;
    endfunction

    // Two's-complement overflow: both addends share a sign the result lacks.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Largest signed value of a dw-bit word (0x7F..F).
    function automatic logic [SAT_MAX_W-1:0] sat_max(input int dw);
        return (SAT_MAX_W'(1) << (dw - 1)) - SAT_MAX_W'(1);
    endfunction

    // Smallest signed value of a dw-bit word (0x80..0).
    function automatic logic [SAT_MAX_W-1:0] sat_min(input int dw);
        return SAT_MAX_W'(1) << (dw - 1);
    endfunction

endpackage

// File: rtl/add_pipe_if.sv
// add_pipe_if: operand/result handshake bundle of the pipelined adder.
// The sat request only exists when ADD_PIPE_SAT_EN is defined.
interface add_pipe_if
    import add_pkg::*;
#(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          opt_sub;
    logic          cin;
`ifdef ADD_PIPE_SAT_EN
    logic          sat;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] sum;
    logic          cout;
    logic          zero;
    logic          neg;
    logic          overflow;

    modport master (
`ifdef ADD_PIPE_SAT_EN
        output sat,
`endif
        output in_valid, a, b, opt_sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, zero, neg, overflow
    );

    modport slave (
`ifdef ADD_PIPE_SAT_EN
        input  sat,
`endif
        input  in_valid, a, b, opt_sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, zero, neg, overflow
    );

endinterface

// File: rtl/add_stage.sv
// add_stage: one registered CW-bit slice of the pipelined adder.
// The incoming carry may be 0..2 because stage 0 injects opt_sub + cin.
// CO_W is 2 for inner slices (a carry of 2 can ripple on) and 1 for the last
// slice, whose single carry bit is the adder's cout.
module add_stage #(
    parameter int CW   = 8,
    parameter int CO_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            in_valid,
    input  logic [CW-1:0]   a,
    input  logic [CW-1:0]   b,
    input  logic [1:0]      cin,
    output logic            out_valid,
    output logic [CW-1:0]   sum,
    output logic [CO_W-1:0] cout
);
    localparam int TW = CW + CO_W;

    logic [TW-1:0] total;

    assign total = TW'(a) + TW'(b) + TW'(cin);

    // Capture chunk sum, carry and slot valid; the slot freezes while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            sum       <= total[CW-1:0];
            cout      <= total[TW-1:CW];
        end
    end

endmodule

// File: rtl/add_pipe.sv
// add_pipe: pipelined DW-bit adder/subtractor, one CW-bit slice per stage.
// Operand chunks not yet added travel down with the slot, finished low sum
// chunks are collected behind it, and a global stall freezes every stage.
// Optional feature macro: ADD_PIPE_SAT_EN (adds the sat input and clamping).
module add_pipe
    import add_pkg::*;
#(
    parameter int DW     = 32,
    parameter int STAGES = 4
) (
    input logic       clk,
    input logic       rst_n,
    add_pipe_if.slave bus
);
    localparam int CW = chunk_width(DW, STAGES);

    logic          stall;
    logic          en;
    logic          last_valid;
    logic [DW-1:0] bx;
    logic [1:0]    inj;
    logic [DW-1:0] sum_raw;
    logic [DW-1:0] sum_out;
    logic          ovf;

    assign stall        = last_valid & ~bus.out_ready;
    assign en           = ~stall;
    assign bus.in_ready = ~stall;
    assign bx           = bus.b ^ {DW{bus.opt_sub}};
    assign inj          = {1'b0, bus.opt_sub} + {1'b0, bus.cin};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RW   = DW - k * CW;
        localparam int CO_W = (k == STAGES - 1) ? 1 : 2;

        logic [RW-1:0]         a_in;
        logic [RW-1:0]         bx_in;
        logic [1:0]            c_in;
        logic                  v_in;
        logic                  a_msb_d;
        logic                  bx_msb_d;
        logic                  a_msb;
        logic                  bx_msb;
        logic                  valid;
        logic [CW-1:0]         s_chunk;
        logic [CO_W-1:0]       carry;
        logic [(k+1)*CW-1:0]   lo;
`ifdef ADD_PIPE_SAT_EN
        logic                  sat_d;
        logic                  sat_q;
`endif

        if (k == 0) begin : g_first
            assign a_in     = bus.a;
            assign bx_in    = bx;
            assign c_in     = inj;
            assign v_in     = bus.in_valid;
            assign a_msb_d  = bus.a[DW-1];
            assign bx_msb_d = bx[DW-1];
`ifdef ADD_PIPE_SAT_EN
            assign sat_d    = bus.sat;
`endif
            assign lo       = s_chunk;
        end else begin : g_next
            logic [k*CW-1:0] lo_q;

            assign c_in     = g_stage[k-1].carry;
            assign v_in     = g_stage[k-1].valid;
            assign a_msb_d  = g_stage[k-1].a_msb;
            assign bx_msb_d = g_stage[k-1].bx_msb;
`ifdef ADD_PIPE_SAT_EN
            assign sat_d    = g_stage[k-1].sat_q;
`endif
            assign lo       = {s_chunk, lo_q};

            // Forward the operand chunks still to be added and the finished low sum.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_in  <= '0;
                    bx_in <= '0;
                    lo_q  <= '0;
                end else if (en) begin
                    a_in  <= g_stage[k-1].a_in[DW-(k-1)*CW-1:CW];
                    bx_in <= g_stage[k-1].bx_in[DW-(k-1)*CW-1:CW];
                    lo_q  <= g_stage[k-1].lo;
                end
            end
        end

        add_stage #(
            .CW   (CW),
            .CO_W (CO_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (v_in),
            .a         (a_in[CW-1:0]),
            .b         (bx_in[CW-1:0]),
            .cin       (c_in),
            .out_valid (valid),
            .sum       (s_chunk),
            .cout      (carry)
        );

        // Carry the operand sign bits (and saturation request) alongside the slot.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_msb  <= 1'b0;
                bx_msb <= 1'b0;
`ifdef ADD_PIPE_SAT_EN
                sat_q  <= 1'b0;
`endif
            end else if (en) begin
                a_msb  <= a_msb_d;
                bx_msb <= bx_msb_d;
`ifdef ADD_PIPE_SAT_EN
                sat_q  <= sat_d;
`endif
            end
        end
    end

    assign last_valid = g_stage[STAGES-1].valid;
    assign sum_raw    = g_stage[STAGES-1].lo;
    assign ovf        = add_ovf(g_stage[STAGES-1].a_msb, g_stage[STAGES-1].bx_msb, sum_raw[DW-1]);

`ifdef ADD_PIPE_SAT_EN
    assign sum_out = (g_stage[STAGES-1].sat_q && ovf)
                   ? (g_stage[STAGES-1].a_msb ? DW'(sat_min(DW)) : DW'(sat_max(DW)))
                   : sum_raw;
`else
    assign sum_out = sum_raw;
`endif

    assign bus.out_valid = last_valid;
    assign bus.sum       = sum_out;
    assign bus.cout      = g_stage[STAGES-1].carry[0];
    assign bus.zero      = (sum_out == '0);
    assign bus.neg       = sum_out[DW-1];
    assign bus.overflow  = ovf;

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed self-checking bench for add_pipe (DW=32, STAGES=4).
// Covers reset values, add/sub/carry/overflow vectors, a stalled back-to-back
// stream and an asynchronous reset with operations in flight.
module tb_add_pipe;
    import add_pkg::*;

    localparam int DW     = 32;
    localparam int STAGES = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    add_pipe_if #(.DW(DW)) bus ();

    add_pipe #(
        .DW     (DW),
        .STAGES (STAGES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int            idx;
    int            rx;
    int            stale;
    logic          acc;
    logic          prev_stall;
    logic [31:0]   hold_sum;
    logic [3:0]    hold_flags;
    logic [32:0]   exp_v;
    logic [32:0]   exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic ci);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.opt_sub  = sub;
        bus.cin      = ci;
    endtask

    function automatic logic [31:0] op_a(input int i);
        return 32'h1111_1111 * 32'(i + 1);
    endfunction

    function automatic logic [31:0] op_b(input int i);
        return 32'h0F0F_0F0F + 32'(i);
    endfunction

    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub, input logic ci);
        return {1'b0, a} + {1'b0, b ^ {32{sub}}} + 33'(sub) + 33'(ci);
    endfunction

    task automatic run_single(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic sub, input logic ci,
                              input logic [31:0] e_sum, input logic e_cout,
                              input logic e_zero, input logic e_neg, input logic e_ovf);
        int cycles;
        apply_stimulus(a, b, sub, ci);
        tick();
        bus.in_valid = 1'b0;
        cycles = 1;
        while (bus.out_valid !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        check_output({tag, "_latency"}, 64'(cycles), 64'd4);
        check_output({tag, "_sum"},  64'(bus.sum),      64'(e_sum));
        check_output({tag, "_cout"}, 64'(bus.cout),     64'(e_cout));
        check_output({tag, "_zero"}, 64'(bus.zero),     64'(e_zero));
        check_output({tag, "_neg"},  64'(bus.neg),      64'(e_neg));
        check_output({tag, "_ovf"},  64'(bus.overflow), 64'(e_ovf));
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.opt_sub   = 1'b0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
`ifdef ADD_PIPE_SAT_EN
        bus.sat       = 1'b0;
`endif

        // Reset values
        #1 rst_n = 1'b0;
        #10;
        check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_output("rst_sum",       64'(bus.sum),       64'd0);
        check_output("rst_zero",      64'(bus.zero),      64'd1);
        check_output("rst_cout",      64'(bus.cout),      64'd0);
        check_output("rst_neg",       64'(bus.neg),       64'd0);
        check_output("rst_ovf",       64'(bus.overflow),  64'd0);
        rst_n = 1'b1;
        tick();
        check_output("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed single operations
        run_single("add_ff_1",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
                   32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        run_single("sub_5_7",   32'd5, 32'd7, 1'b1, 1'b0,
                   32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        run_single("sub_7_5",   32'd7, 32'd5, 1'b1, 1'b0,
                   32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
        run_single("ripple",    32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1,
                   32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_single("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                   32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        run_single("neg_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0,
                   32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef ADD_PIPE_SAT_EN
        bus.sat = 1'b1;
        run_single("sat_pos",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                   32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        run_single("sat_neg",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0,
                   32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
        bus.sat = 1'b0;
`endif

        // Eight back-to-back operations with out_ready low in cycles 5..7
        idx        = 0;
        rx         = 0;
        prev_stall = 1'b0;
        for (int cyc = 1; cyc <= 40 && rx < 8; cyc++) begin
            bus.out_ready = !(cyc >= 5 && cyc <= 7);
            if (idx < 8)
                apply_stimulus(op_a(idx), op_b(idx), idx[0], idx[1]);
            else
                bus.in_valid = 1'b0;
            #1;
            if (cyc >= 5 && cyc <= 7) begin
                check_output("stall_in_ready",  64'(bus.in_ready),  64'd0);
                check_output("stall_out_valid", 64'(bus.out_valid), 64'd1);
            end
            if (prev_stall) begin
                check_output("stall_hold_valid", 64'(bus.out_valid), 64'd1);
                check_output("stall_hold_sum",   64'(bus.sum),       64'(hold_sum));
                check_output("stall_hold_flags",
                             64'({bus.cout, bus.zero, bus.neg, bus.overflow}), 64'(hold_flags));
            end
            prev_stall = bus.out_valid & ~bus.out_ready;
            hold_sum   = bus.sum;
            hold_flags = {bus.cout, bus.zero, bus.neg, bus.overflow};
            if (bus.out_valid && bus.out_ready) begin
                check_output("stream_not_extra", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    check_output("stream_sum",   64'(bus.sum),  64'(exp_v[31:0]));
                    check_output("stream_cout",  64'(bus.cout), 64'(exp_v[32]));
                    check_output("stream_cycle", 64'(cyc),      64'(8 + rx));
                    rx++;
                end
            end
            acc = bus.in_valid & bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(ref_add(op_a(idx), op_b(idx), idx[0], idx[1]));
                idx++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check_output("stream_received", 64'(rx), 64'd8);
        check_output("stream_drained",  64'(exp_q.size()), 64'd0);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid === 1'b1) stale++;
            tick();
        end
        check_output("stream_no_dup", 64'(stale), 64'd0);

        // Asynchronous reset with three operations in flight
        bus.out_ready = 1'b0;
        apply_stimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        apply_stimulus(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        apply_stimulus(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check_output("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        check_output("pre_rst_sum",   64'(bus.sum),       64'h8000_0000);
        #3 rst_n = 1'b0;
        #1;
        check_output("async_rst_valid", 64'(bus.out_valid), 64'd0);
        check_output("async_rst_sum",   64'(bus.sum),       64'd0);
        check_output("async_rst_zero",  64'(bus.zero),      64'd1);
        check_output("async_rst_ovf",   64'(bus.overflow),  64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid === 1'b1) stale++;
        end
        check_output("post_rst_no_stale", 64'(stale), 64'd0);
        check_output("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        run_single("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
                   32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
